// File: rtl/masku_result_packer_pkg.sv
// Shared types and helpers for the mask-unit result packer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package masku_result_packer_pkg;

   localparam int unsigned ELEN = 64;

   typedef enum logic [1:0] {
      EW8  = 2'd0,
      EW16 = 2'd1,
      EW32 = 2'd2,
      EW64 = 2'd3
   } vew_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2
   } masku_pack_state_e;

   // One comparison bit per element: a beat of NrLanes*ELEN source bits
   // carries DW/SEW elements, i.e. DW >> (vsew+3).
   function automatic int unsigned elems_per_beat(input int unsigned nr_lanes, input vew_e vew);
      return (nr_lanes * ELEN) >> (int'(vew) + 3);
   endfunction

endpackage

// File: rtl/masku_result_packer_if.sv
// Beat input and per-lane writeback bundle of the mask result packer.
// Latency: n/a (wiring only).
// Backpressure: beat valid/ready, per-lane writeback valid/ready.
interface masku_result_packer_if #(
   parameter int unsigned NrLanes = 4
);
   import masku_result_packer_pkg::*;

   localparam int unsigned DW = NrLanes * ELEN;

   // Compressed comparison beat from the operand stage
   logic                               in_valid;
   logic                               in_ready;
   logic [DW-1:0]                      res_bits;
   logic [DW-1:0]                      wr_mask;
   logic [DW-1:0]                      act_mask;
   logic [DW-1:0]                      vd_old;

   // Per-lane writeback of completed mask words
   logic [NrLanes-1:0][ELEN-1:0]       result;
   logic [NrLanes-1:0][ELEN/8-1:0]     result_be;
   logic [NrLanes-1:0]                 result_valid;
   logic [NrLanes-1:0]                 result_ready;

   modport master (
      output in_valid, res_bits, wr_mask, act_mask, vd_old, result_ready,
      input  in_ready, result, result_be, result_valid
   );

   modport slave (
      input  in_valid, res_bits, wr_mask, act_mask, vd_old, result_ready,
      output in_ready, result, result_be, result_valid
   );

endinterface

// File: rtl/masku_result_packer_lane_wb_arbiter.sv
// Tracks which lanes have accepted the current mask word and raises their valids.
// Latency: valid is combinational from the ack register; acks register on the ready edge.
// Backpressure: each lane holds valid until its ready; all_acked asserts in the last-ack cycle.
module masku_lane_wb_arbiter #(
   parameter int unsigned NrLanes = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               i_active,
   input  logic [NrLanes-1:0] i_strb_nz,
   input  logic [NrLanes-1:0] i_ready,
   output logic [NrLanes-1:0] o_valid,
   output logic               o_all_acked
);

   logic [NrLanes-1:0] r_acked;
   logic [NrLanes-1:0] w_acked_nxt;

   // Lanes with nothing to write count as acked without ever raising valid
   always_comb begin
      o_valid     = {NrLanes{i_active}} & ~r_acked & i_strb_nz;
      w_acked_nxt = r_acked | ~i_strb_nz | (o_valid & i_ready);
      o_all_acked = i_active & (&w_acked_nxt);
   end

   // Accumulate acks while flushing; clear once the whole word is written
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_acked <= '0;
      end else if (i_active) begin
         r_acked <= o_all_acked ? '0 : w_acked_nxt;
      end
   end

endmodule

// File: rtl/masku_result_packer.sv
// Packs compressed mask-unit comparison bits into full mask words and writes them to the lanes.
// Latency: writeback valid one cycle after the closing beat; done with the last lane ack.
// Backpressure: in_ready only in ACCUM; FLUSH waits for every lane with a nonzero strobe.
module masku_result_packer
   import masku_result_packer_pkg::*;
#(
   parameter  int unsigned NrLanes  = 4,
   parameter  int unsigned ElemCntW = 16,
   localparam int unsigned DW       = NrLanes * ELEN,
   localparam int unsigned PntW     = $clog2(DW) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ElemCntW-1:0]   vl_i,
   input  vew_e                  vsew_i,
   output logic                  busy_o,
   masku_result_packer_if.slave  bus,
   output logic [PntW-1:0]       vrf_pnt_o,
   output logic                  done_o
);

   masku_pack_state_e            r_state, w_state_nxt;
   vew_e                         r_vsew;
   logic [ElemCntW-1:0]          r_remaining;
   logic [PntW-1:0]              r_vrf_pnt;
   logic [DW-1:0]                r_acc_data;
   logic [DW-1:0]                r_acc_bits;

   logic                         w_fire;
   logic                         w_load;
   logic                         w_clear_word;
   logic                         w_done;
   logic                         w_flush_trig;
   logic                         w_all_acked;
   logic [ElemCntW-1:0]          w_epb_full;
   logic [ElemCntW-1:0]          w_epb;
   logic [ElemCntW-1:0]          w_rem_nxt;
   logic [PntW-1:0]              w_pnt_nxt;
   logic [DW-1:0]                w_merged;
   logic [NrLanes-1:0]           w_strb_nz;
   logic [NrLanes-1:0]           w_valid;

   // Beat bookkeeping: epb is clipped to the remaining elements so the counter never wraps
   always_comb begin
      w_fire       = bus.in_valid && (r_state == ACCUM);
      w_epb_full   = ElemCntW'(elems_per_beat(NrLanes, r_vsew));
      w_epb        = (w_epb_full > r_remaining) ? r_remaining : w_epb_full;
      w_rem_nxt    = r_remaining - w_epb;
      w_pnt_nxt    = r_vrf_pnt + PntW'(w_epb);
      w_flush_trig = (w_pnt_nxt == PntW'(DW)) || (w_rem_nxt == '0);
      w_merged     = (bus.act_mask & bus.res_bits) | (~bus.act_mask & bus.vd_old);
   end

   // Next state and control strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_clear_word = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_load      = 1'b1;
               // vl=0 goes straight to an empty flush, which completes at once
               w_state_nxt = (vl_i == '0) ? FLUSH : ACCUM;
            end
         end
         ACCUM: begin
            if (w_fire && w_flush_trig) begin
               w_state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (w_all_acked) begin
               if (r_remaining == '0) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_clear_word = 1'b1;
                  w_state_nxt  = ACCUM;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Accumulator, write pointer and element counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vsew      <= EW8;
         r_remaining <= '0;
         r_vrf_pnt   <= '0;
         r_acc_data  <= '0;
         r_acc_bits  <= '0;
      end else if (w_load) begin
         r_vsew      <= vsew_i;
         r_remaining <= vl_i;
         r_vrf_pnt   <= '0;
         r_acc_data  <= '0;
         r_acc_bits  <= '0;
      end else if (w_fire) begin
         r_vrf_pnt   <= w_pnt_nxt;
         r_remaining <= w_rem_nxt;
         r_acc_data  <= (r_acc_data & ~bus.wr_mask) | (w_merged & bus.wr_mask);
         r_acc_bits  <= r_acc_bits | bus.wr_mask;
      end else if (w_clear_word || w_done) begin
         // Clearing on done too keeps result lines quiet while idle
         r_vrf_pnt   <= '0;
         r_acc_data  <= '0;
         r_acc_bits  <= '0;
      end
   end

   // Lane slices of the accumulator and byte strobes from the produced-bit map
   always_comb begin
      for (int l = 0; l < int'(NrLanes); l++) begin
         bus.result[l] = r_acc_data[l*ELEN +: ELEN];
         for (int k = 0; k < int'(ELEN/8); k++) begin
            bus.result_be[l][k] = |r_acc_bits[l*ELEN + k*8 +: 8];
         end
         w_strb_nz[l] = |r_acc_bits[l*ELEN +: ELEN];
      end
   end

   masku_lane_wb_arbiter #(
      .NrLanes     (NrLanes)
   ) u_wb_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_active    (r_state == FLUSH),
      .i_strb_nz   (w_strb_nz),
      .i_ready     (bus.result_ready),
      .o_valid     (w_valid),
      .o_all_acked (w_all_acked)
   );

   assign bus.result_valid = w_valid;
   assign bus.in_ready     = (r_state == ACCUM);
   assign busy_o           = (r_state != IDLE);
   assign vrf_pnt_o        = r_vrf_pnt;
   assign done_o           = w_done;

endmodule

// File: tb/tb_masku_result_packer.sv
module tb_masku_result_packer;
   import masku_result_packer_pkg::*;

   localparam int unsigned NrLanes  = 4;
   localparam int unsigned ElemCntW = 16;
   localparam int unsigned DW       = NrLanes * ELEN;
   localparam int unsigned PntW     = $clog2(DW) + 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [ElemCntW-1:0] vl = '0;
   vew_e                vsew = EW8;
   logic                busy;
   logic                done;
   logic [PntW-1:0]     vrf_pnt;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   // Scoreboard: expected writeback words per lane
   logic [ELEN-1:0] exp_d_q  [NrLanes][$];
   logic [7:0]      exp_be_q [NrLanes][$];

   // Reference accumulator for the current mask word
   logic [DW-1:0] m_data;
   logic [DW-1:0] m_bits;

   masku_result_packer_if #(.NrLanes(NrLanes)) bus ();

   masku_result_packer #(
      .NrLanes  (NrLanes),
      .ElemCntW (ElemCntW)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .vl_i      (vl),
      .vsew_i    (vsew),
      .busy_o    (busy),
      .bus       (bus),
      .vrf_pnt_o (vrf_pnt),
      .done_o    (done)
   );

   always #5 clk = ~clk;

   // Writeback monitor: pops the scoreboard on each lane handshake, checks hold stability
   logic [NrLanes-1:0]  prev_v;
   logic [ELEN-1:0]     prev_d  [NrLanes];
   logic [7:0]          prev_be [NrLanes];
   logic [ELEN-1:0]     ed;
   logic [7:0]          eb;

   always @(negedge clk) begin
      if (rst) begin
         prev_v = '0;
      end else begin
         if (done) done_cnt++;
         for (int l = 0; l < int'(NrLanes); l++) begin
            if (bus.result_valid[l]) begin
               if (prev_v[l]) begin
                  checks++;
                  if (bus.result[l] !== prev_d[l] || bus.result_be[l] !== prev_be[l]) begin
                     errors++;
                     $display("FAIL wb_stable lane%0d: data %h be %h, held %h be %h", l,
                              bus.result[l], bus.result_be[l], prev_d[l], prev_be[l]);
                  end
               end
               if (bus.result_ready[l]) begin
                  checks++;
                  if (exp_d_q[l].size() == 0) begin
                     errors++;
                     $display("FAIL wb_unexpected lane%0d: data %h be %h, required no write", l,
                              bus.result[l], bus.result_be[l]);
                  end else begin
                     ed = exp_d_q[l].pop_front();
                     eb = exp_be_q[l].pop_front();
                     if (bus.result[l] !== ed || bus.result_be[l] !== eb) begin
                        errors++;
                        $display("FAIL wb_data lane%0d: data %h be %h, required %h be %h", l,
                                 bus.result[l], bus.result_be[l], ed, eb);
                     end
                  end
                  prev_v[l] = 1'b0;
               end else begin
                  prev_v[l]  = 1'b1;
                  prev_d[l]  = bus.result[l];
                  prev_be[l] = bus.result_be[l];
               end
            end else begin
               prev_v[l] = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic model_beat(input logic [DW-1:0] res, wr, act, vd);
      m_data = (m_data & ~wr) | (((act & res) | (~act & vd)) & wr);
      m_bits = m_bits | wr;
   endtask

   task automatic model_flush();
      logic [7:0] be;
      for (int l = 0; l < int'(NrLanes); l++) begin
         for (int k = 0; k < 8; k++) be[k] = |m_bits[l*ELEN + k*8 +: 8];
         if (be != 8'h00) begin
            exp_d_q[l].push_back(m_data[l*ELEN +: ELEN]);
            exp_be_q[l].push_back(be);
         end
      end
      m_data = '0;
      m_bits = '0;
   endtask

   task automatic do_start(input logic [ElemCntW-1:0] n, input vew_e ew);
      @(posedge clk); #1;
      start = 1'b1; vl = n; vsew = ew;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] res, wr, act, vd);
      bit fired = 1'b0;
      @(posedge clk); #1;
      bus.res_bits = res; bus.wr_mask = wr; bus.act_mask = act; bus.vd_old = vd;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50 && !fired; i++) begin
         @(negedge clk);
         if (bus.in_ready) fired = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (!fired) begin
         errors++;
         $display("FAIL beat_accept: in_ready never seen, required within 50 cycles");
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < int'(DW/32); i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: %b, required 0", bus.in_ready); end
      checks++; if (vrf_pnt !== '0) begin errors++; $display("FAIL reset_vrf_pnt: %0d, required 0", vrf_pnt); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b, required 0", done); end
      checks++; if (bus.result_valid !== '0) begin errors++; $display("FAIL reset_valid: %b, required 0", bus.result_valid); end
      checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result: %h, required 0", bus.result); end
      checks++; if (bus.result_be !== '0) begin errors++; $display("FAIL reset_be: %h, required 0", bus.result_be); end
   endtask

   task automatic test_reset_mid_flush();
      logic [DW-1:0] wr = '0;
      int d0;
      for (int l = 0; l < int'(NrLanes); l++) wr[l*ELEN] = 1'b1;
      bus.result_ready = '0;
      for (int l = 0; l < 2; l++) begin
         exp_d_q[l].push_back(64'h1);
         exp_be_q[l].push_back(8'h01);
      end
      d0 = done_cnt;
      do_start(16'd4, EW64);
      send_beat('1, wr, '1, '0);
      @(posedge clk); #1 bus.result_ready = 4'b0011;
      @(negedge clk);
      checks++; if (bus.result_valid !== 4'b1111) begin errors++; $display("FAIL midflush_valid_all: %b, required 1111", bus.result_valid); end
      @(posedge clk); #1 bus.result_ready = 4'b0000;
      @(negedge clk);
      checks++; if (bus.result_valid !== 4'b1100) begin errors++; $display("FAIL midflush_valid_rest: %b, required 1100", bus.result_valid); end
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: %b, required 0", busy); end
      checks++; if (bus.result_valid !== '0) begin errors++; $display("FAIL abort_valid: %b, required 0", bus.result_valid); end
      checks++; if (vrf_pnt !== '0) begin errors++; $display("FAIL abort_vrf_pnt: %0d, required 0", vrf_pnt); end
      checks++; if (bus.result !== '0 || bus.result_be !== '0) begin errors++; $display("FAIL abort_result: %h be %h, required 0", bus.result, bus.result_be); end
      @(posedge clk); #1;
      checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_done: %0d pulses, required 0", done_cnt - d0); end
   endtask

   task automatic test_single();
      int d0 = done_cnt;
      bus.result_ready = '1;
      exp_d_q[0].push_back(64'h000F);
      exp_be_q[0].push_back(8'h01);
      do_start(16'd4, EW64);
      @(negedge clk);
      checks++; if (vrf_pnt !== 9'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_accum: pnt %0d rdy %b, required 0 1", vrf_pnt, bus.in_ready); end
      send_beat(256'hF, 256'hF, 256'hF, '0);
      @(negedge clk);
      checks++; if (vrf_pnt !== 9'd4) begin errors++; $display("FAIL single_pnt: %0d, required 4", vrf_pnt); end
      checks++; if (bus.result_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: %b, required 0001", bus.result_valid); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: %b, required 1", done); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: done %b busy %b, required 0 0", done, busy); end
      @(posedge clk); #1;
      checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL single_done_cnt: %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_masked();
      int d0 = done_cnt;
      exp_d_q[0].push_back(64'hA);
      exp_be_q[0].push_back(8'h01);
      do_start(16'd4, EW64);
      send_beat(256'h0, 256'hF, 256'h5, 256'hA);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL masked_done: %b, required 1", done); end
      @(posedge clk); #1;
      checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL masked_done_cnt: %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_ew8_long();
      int d0 = done_cnt;
      int pnt = 0;
      int n;
      logic [DW-1:0] res, wr, act, vd;
      m_data = '0; m_bits = '0;
      bus.result_ready = '1;
      do_start(16'd300, EW8);
      for (int b = 0; b < 10; b++) begin
         n = (b == 9) ? 12 : 32;
         wr = '0;
         for (int i = 0; i < n; i++) wr[pnt + i] = 1'b1;
         res = rand_word(); act = rand_word(); vd = rand_word();
         model_beat(res, wr, act, vd);
         if (b == 7 || b == 9) model_flush();
         send_beat(res, wr, act, vd);
         @(negedge clk);
         if (b == 0) begin
            checks++; if (vrf_pnt !== 9'd32) begin errors++; $display("FAIL ew8_pnt_first: %0d, required 32", vrf_pnt); end
         end
         if (b == 7) begin
            checks++; if (vrf_pnt !== 9'd256) begin errors++; $display("FAIL ew8_pnt_full: %0d, required 256", vrf_pnt); end
            checks++; if (bus.result_valid !== 4'b1111 || done !== 1'b0) begin errors++; $display("FAIL ew8_flush1: valid %b done %b, required 1111 0", bus.result_valid, done); end
         end
         if (b == 9) begin
            checks++; if (vrf_pnt !== 9'd44) begin errors++; $display("FAIL ew8_pnt_tail: %0d, required 44", vrf_pnt); end
            checks++; if (bus.result_valid !== 4'b0001 || done !== 1'b1) begin errors++; $display("FAIL ew8_flush2: valid %b done %b, required 0001 1", bus.result_valid, done); end
         end
         pnt = (b == 7) ? 0 : pnt + n;
      end
      @(posedge clk); #1;
      checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ew8_done_cnt: %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_ack_order();
      int d0 = done_cnt;
      logic [3:0] pat [7];
      logic [3:0] acked = '0;
      logic [DW-1:0] res, wr;
      pat = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
      wr = '0;
      for (int l = 0; l < int'(NrLanes); l++) wr[l*ELEN +: 4] = 4'hF;
      res = rand_word();
      m_data = '0; m_bits = '0;
      model_beat(res, wr, '1, '0);
      model_flush();
      bus.result_ready = '0;
      do_start(16'd4, EW64);
      send_beat(res, wr, '1, '0);
      @(negedge clk);
      checks++; if (bus.result_valid !== 4'b1111 || done !== 1'b0) begin errors++; $display("FAIL order_start: valid %b done %b, required 1111 0", bus.result_valid, done); end
      for (int s = 0; s < 7; s++) begin
         @(posedge clk); #1 bus.result_ready = pat[s];
         @(negedge clk);
         checks++; if (bus.result_valid !== ~acked) begin errors++; $display("FAIL order_valid step%0d: %b, required %b", s, bus.result_valid, ~acked); end
         checks++; if (done !== (s == 6)) begin errors++; $display("FAIL order_done step%0d: %b, required %b", s, done, (s == 6)); end
         acked = acked | pat[s];
      end
      @(posedge clk); #1 bus.result_ready = '1;
      checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL order_done_cnt: %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_vl0_and_busy_start();
      int d0 = done_cnt;
      bus.result_ready = '1;
      do_start(16'd0, EW8);
      @(negedge clk);
      checks++; if (done !== 1'b1 || bus.result_valid !== '0) begin errors++; $display("FAIL vl0_done: done %b valid %b, required 1 0000", done, bus.result_valid); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL vl0_idle: busy %b done %b, required 0 0", busy, done); end
      exp_d_q[0].push_back(64'hF);
      exp_be_q[0].push_back(8'h01);
      do_start(16'd4, EW64);
      @(posedge clk); #1 start = 1'b1; vl = 16'd0; vsew = EW8;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1 || vrf_pnt !== '0 || done !== 1'b0) begin
         errors++; $display("FAIL busy_start: busy %b rdy %b pnt %0d done %b, required 1 1 0 0", busy, bus.in_ready, vrf_pnt, done);
      end
      send_beat(256'hF, 256'hF, 256'hF, '0);
      @(negedge clk);
      checks++; if (vrf_pnt !== 9'd4 || done !== 1'b1) begin errors++; $display("FAIL busy_start_beat: pnt %0d done %b, required 4 1", vrf_pnt, done); end
      @(posedge clk); #1;
      checks++; if (done_cnt !== d0 + 2) begin errors++; $display("FAIL vl0_done_cnt: %0d, required 2", done_cnt - d0); end
   endtask

   task automatic test_drain();
      for (int l = 0; l < int'(NrLanes); l++) begin
         checks++;
         if (exp_d_q[l].size() != 0) begin
            errors++;
            $display("FAIL drain lane%0d: %0d writes outstanding, required 0", l, exp_d_q[l].size());
         end
      end
   endtask

   initial begin
      bus.in_valid     = 1'b0;
      bus.res_bits     = '0;
      bus.wr_mask      = '0;
      bus.act_mask     = '0;
      bus.vd_old       = '0;
      bus.result_ready = '0;
      m_data           = '0;
      m_bits           = '0;
      test_reset();
      test_reset_mid_flush();
      test_single();
      test_masked();
      test_ew8_long();
      test_ack_order();
      test_vl0_and_busy_start();
      repeat (3) @(posedge clk);
      test_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
